// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: control codes, forward-select
// encoding and default widths.
package alu_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
   localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
   localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
   localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
   localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;
   localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;

   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_EXM  = 2'd1,
      FWD_MWB  = 2'd2
   } fwd_sel_t;
endpackage

// File: rtl/alu_fwd_mux.sv
// Per-operand forwarding mux: EX/MEM beats MEM/WB, x0 is never forwarded.
// The select is exposed only when ALU_OPSTAGE_PERF_EN is defined.
module alu_fwd_mux
   import alu_pkg::*;
#(
   parameter int XLEN   = alu_pkg::XLEN,
   parameter int REG_AW = alu_pkg::REG_AW
) (
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [XLEN-1:0]   rs_data,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic              exm_reg_write,
   input  logic [XLEN-1:0]   exm_result,
   input  logic [REG_AW-1:0] mwb_rd,
   input  logic              mwb_reg_write,
   input  logic [XLEN-1:0]   mwb_data,
`ifdef ALU_OPSTAGE_PERF_EN
   output fwd_sel_t          sel,
`endif
   output logic [XLEN-1:0]   data
);
   fwd_sel_t sel_int;

   always_comb begin
      sel_int = FWD_NONE;
      if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs_addr))
         sel_int = FWD_EXM;
      else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs_addr))
         sel_int = FWD_MWB;
   end

   always_comb begin
      case (sel_int)
         FWD_EXM: data = exm_result;
         FWD_MWB: data = mwb_data;
         default: data = rs_data;
      endcase
   end

`ifdef ALU_OPSTAGE_PERF_EN
   assign sel = sel_int;
`endif
endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register for the ALU with operand forwarding and load-use detection.
// Optional ALU_OPSTAGE_PERF_EN adds forward/stall performance counters.
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int XLEN   = alu_pkg::XLEN,
   parameter int REG_AW = alu_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic              id_alu_src,
   input  logic [3:0]        id_alu_ctrl,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic              exm_reg_write,
   input  logic [XLEN-1:0]   exm_result,
   input  logic [REG_AW-1:0] mwb_rd,
   input  logic              mwb_reg_write,
   input  logic [XLEN-1:0]   mwb_data,
   output logic              ex_valid,
   output logic [XLEN-1:0]   src1,
   output logic [XLEN-1:0]   src2,
   output logic [3:0]        ALU_control,
   output logic [XLEN-1:0]   ex_store_data,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
`ifdef ALU_OPSTAGE_PERF_EN
   output logic [31:0]       perf_fwd_cnt,
   output logic [31:0]       perf_stall_cnt,
`endif
   output logic              load_use_stall
);
   localparam int NUM_OPS = 2;

   logic [NUM_OPS-1:0][REG_AW-1:0] rs_addr_q;
   logic [NUM_OPS-1:0][XLEN-1:0]   rs_data_q;
   logic [NUM_OPS-1:0][XLEN-1:0]   fwd_data;
   logic [XLEN-1:0]                imm_q;
   logic                           alu_src_q;
   logic                           bubble;

   assign load_use_stall = !rst && !flush_i && id_valid && ex_valid && ex_mem_read &&
                           (ex_rd != '0) && ((ex_rd == id_rs1_addr) || (ex_rd == id_rs2_addr));

   // An invalid decode slot is loaded exactly like a bubble so no enable leaks through.
   assign bubble = flush_i || (!stall_i && (load_use_stall || !id_valid));

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         rs_addr_q    <= '0;
         rs_data_q    <= '0;
         imm_q        <= '0;
         alu_src_q    <= 1'b0;
         ALU_control  <= ALU_CTRL_AND;
         ex_rd        <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
      end else if (bubble) begin
         ex_valid     <= 1'b0;
         rs_addr_q    <= '0;
         rs_data_q    <= '0;
         imm_q        <= '0;
         alu_src_q    <= 1'b0;
         ALU_control  <= ALU_CTRL_ADD;
         ex_rd        <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
      end else if (!stall_i) begin
         ex_valid     <= 1'b1;
         rs_addr_q    <= {id_rs2_addr, id_rs1_addr};
         rs_data_q    <= {id_rs2_data, id_rs1_data};
         imm_q        <= id_imm;
         alu_src_q    <= id_alu_src;
         ALU_control  <= id_alu_ctrl;
         ex_rd        <= id_rd_addr;
         ex_reg_write <= id_reg_write;
         ex_mem_read  <= id_mem_read;
      end
   end

`ifdef ALU_OPSTAGE_PERF_EN
   fwd_sel_t [NUM_OPS-1:0] fwd_sel;
`endif

   for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
      alu_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd (
         .rs_addr       (rs_addr_q[i]),
         .rs_data       (rs_data_q[i]),
         .exm_rd        (exm_rd),
         .exm_reg_write (exm_reg_write),
         .exm_result    (exm_result),
         .mwb_rd        (mwb_rd),
         .mwb_reg_write (mwb_reg_write),
         .mwb_data      (mwb_data),
`ifdef ALU_OPSTAGE_PERF_EN
         .sel           (fwd_sel[i]),
`endif
         .data          (fwd_data[i])
      );
   end

   assign src1          = fwd_data[0];
   assign src2          = alu_src_q ? imm_q : fwd_data[1];
   assign ex_store_data = fwd_data[1];

`ifdef ALU_OPSTAGE_PERF_EN
   logic fwd_any;
   assign fwd_any = (fwd_sel[0] != FWD_NONE) || (fwd_sel[1] != FWD_NONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fwd_cnt   <= '0;
         perf_stall_cnt <= '0;
      end else if (!stall_i) begin
         if (ex_valid && fwd_any) perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
         if (load_use_stall)      perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, forwarding priority, x0, load-use,
// flush/stall interaction and mid-operation reset.
module tb_alu_operand_stage;
   logic        clk = 1'b0;
   logic        rst, stall_i, flush_i, id_valid;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic        id_alu_src, id_reg_write, id_mem_read;
   logic [3:0]  id_alu_ctrl;
   logic [4:0]  exm_rd, mwb_rd;
   logic        exm_reg_write, mwb_reg_write;
   logic [31:0] exm_result, mwb_data;
   logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
   logic [31:0] src1, src2, ex_store_data;
   logic [3:0]  ALU_control;
   logic [4:0]  ex_rd;
`ifdef ALU_OPSTAGE_PERF_EN
   logic [31:0] perf_fwd_cnt, perf_stall_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .id_rd_addr(id_rd_addr),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
      .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_data(mwb_data),
      .ex_valid(ex_valid), .src1(src1), .src2(src2), .ALU_control(ALU_control),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read),
`ifdef ALU_OPSTAGE_PERF_EN
      .perf_fwd_cnt(perf_fwd_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
      .load_use_stall(load_use_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2,
                         input logic [31:0] imm, input logic asrc, input logic [3:0] ctrl,
                         input logic [4:0] rd, input logic rw, input logic mr);
      id_valid = 1'b1;
      id_rs1_addr = r1; id_rs1_data = d1;
      id_rs2_addr = r2; id_rs2_data = d2;
      id_imm = imm; id_alu_src = asrc; id_alu_ctrl = ctrl;
      id_rd_addr = rd; id_reg_write = rw; id_mem_read = mr;
   endtask

   task automatic clr_prod();
      exm_rd = 0; exm_reg_write = 0; exm_result = 0;
      mwb_rd = 0; mwb_reg_write = 0; mwb_data = 0;
   endtask

   initial begin
      rst = 1; stall_i = 0; flush_i = 0;
      clr_prod();
      set_id(5'd5, 32'd7, 5'd6, 32'd3, 32'd0, 1'b0, 4'b0010, 5'd7, 1'b1, 1'b0);

      // reset held two cycles with a valid instruction in decode
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_valid", {31'd0, ex_valid}, 32'd0);
         chk("rst_rw", {31'd0, ex_reg_write}, 32'd0);
         chk("rst_ctrl", {28'd0, ALU_control}, 32'd0);
         chk("rst_lus", {31'd0, load_use_stall}, 32'd0);
      end

      // plain ADD
      rst = 0;
      step();
      chk("add_valid", {31'd0, ex_valid}, 32'd1);
      chk("add_src1", src1, 32'd7);
      chk("add_src2", src2, 32'd3);
      chk("add_ctrl", {28'd0, ALU_control}, 32'h2);
      chk("add_rd", {27'd0, ex_rd}, 32'd7);
      chk("add_rw", {31'd0, ex_reg_write}, 32'd1);

      // forwarding priority on rs1, then MEM/WB on rs2
      id_valid = 0;
      exm_rd = 5; exm_reg_write = 1; exm_result = 32'd20;
      mwb_rd = 5; mwb_reg_write = 1; mwb_data = 32'd9;
      #1 chk("fwd_exm", src1, 32'd20);
      chk("fwd_exm_s2", src2, 32'd3);
      exm_reg_write = 0;
      #1 chk("fwd_mwb", src1, 32'd9);
      mwb_reg_write = 0;
      #1 chk("fwd_none", src1, 32'd7);
      mwb_rd = 6; mwb_reg_write = 1; mwb_data = 32'd44;
      #1 chk("fwd_rs2", src2, 32'd44);
      chk("fwd_st", ex_store_data, 32'd44);
      clr_prod();

      // x0 never forwarded; immediate path and store data independent of alu_src
      set_id(5'd0, 32'd0, 5'd2, 32'd5, 32'd100, 1'b1, 4'b0110, 5'd3, 1'b1, 1'b0);
      step();
      id_valid = 0;
      exm_rd = 0; exm_reg_write = 1; exm_result = 32'h0000FFFF;
      mwb_rd = 0; mwb_reg_write = 1; mwb_data = 32'd123;
      #1 chk("x0_src1", src1, 32'd0);
      chk("imm_src2", src2, 32'd100);
      chk("imm_st", ex_store_data, 32'd5);
      chk("sub_ctrl", {28'd0, ALU_control}, 32'h6);
      clr_prod();

      // load-use: LW x8 in EX, SUB using x8 in decode
      set_id(5'd1, 32'd1000, 5'd0, 32'd0, 32'd4, 1'b1, 4'b0010, 5'd8, 1'b1, 1'b1);
      step();
      chk("lw_mr", {31'd0, ex_mem_read}, 32'd1);
      set_id(5'd9, 32'd10, 5'd8, 32'd0, 32'd0, 1'b0, 4'b0110, 5'd10, 1'b1, 1'b0);
      #1 chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
      step();
      chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
      chk("lu_bub_rw", {31'd0, ex_reg_write}, 32'd0);
      chk("lu_bub_ctrl", {28'd0, ALU_control}, 32'h2);
      chk("lu_once", {31'd0, load_use_stall}, 32'd0);
      mwb_rd = 8; mwb_reg_write = 1; mwb_data = 32'd55;
      step();
      chk("lu_sub_valid", {31'd0, ex_valid}, 32'd1);
      chk("lu_sub_src1", src1, 32'd10);
      chk("lu_sub_src2", src2, 32'd55);
      chk("lu_sub_ctrl", {28'd0, ALU_control}, 32'h6);

      // stall alone holds, flush with stall bubbles
      stall_i = 1;
      set_id(5'd3, 32'd99, 5'd4, 32'd98, 32'd0, 1'b0, 4'b0001, 5'd11, 1'b1, 1'b0);
      step();
      chk("stl_src1", src1, 32'd10);
      chk("stl_src2", src2, 32'd55);
      chk("stl_valid", {31'd0, ex_valid}, 32'd1);
      chk("stl_ctrl", {28'd0, ALU_control}, 32'h6);
      flush_i = 1;
      step();
      chk("fl_valid", {31'd0, ex_valid}, 32'd0);
      chk("fl_rw", {31'd0, ex_reg_write}, 32'd0);
      chk("fl_ctrl", {28'd0, ALU_control}, 32'h2);
      flush_i = 0; stall_i = 0;
      clr_prod();

      // flush suppresses load-use; stall does not
      set_id(5'd1, 32'd1000, 5'd0, 32'd0, 32'd4, 1'b1, 4'b0010, 5'd8, 1'b1, 1'b1);
      step();
      set_id(5'd8, 32'd0, 5'd2, 32'd0, 32'd0, 1'b0, 4'b0000, 5'd12, 1'b1, 1'b0);
      flush_i = 1;
      #1 chk("fl_no_lu", {31'd0, load_use_stall}, 32'd0);
      flush_i = 0; stall_i = 1;
      #1 chk("stl_lu", {31'd0, load_use_stall}, 32'd1);
      step();
      chk("stl_lw_hold", {31'd0, ex_mem_read}, 32'd1);
      chk("stl_lw_rd", {27'd0, ex_rd}, 32'd8);
      stall_i = 0;
      step();
      chk("lu2_bub", {31'd0, ex_valid}, 32'd0);

      // unknown control code passes through, then reset mid-operation
      set_id(5'd2, 32'd1, 5'd3, 32'd2, 32'd0, 1'b0, 4'b1111, 5'd13, 1'b1, 1'b0);
      step();
      chk("unk_ctrl", {28'd0, ALU_control}, 32'hF);
      chk("unk_rw", {31'd0, ex_reg_write}, 32'd1);
      rst = 1;
      step();
      chk("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("mid_rst_rw", {31'd0, ex_reg_write}, 32'd0);
      chk("mid_rst_ctrl", {28'd0, ALU_control}, 32'd0);
      rst = 0;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
